// File: rtl/gpio_bank_pkg.sv
// gpio_bank_pkg: shared register-map constants for the GPIO bank.
//   REG_DATA/REG_DDR/REG_IER/REG_IFR : per-port register offsets from port base
//   REGS_PER_PORT                    : address stride between ports
//   pol_addr()                       : address of the global POL register
package gpio_bank_pkg;

  localparam int REG_DATA      = 0;
  localparam int REG_DDR       = 1;
  localparam int REG_IER       = 2;
  localparam int REG_IFR       = 3;
  localparam int REGS_PER_PORT = 4;

  // The POL register sits directly after the last port's register block.
  function automatic int pol_addr(input int nports);
    return REGS_PER_PORT * nports;
  endfunction

endpackage

// File: rtl/gpio_port.sv
// gpio_port: one bidirectional GPIO port.
// Holds the output register (OR), data-direction register (DDR), interrupt
// enable (IER) and sticky interrupt flags (IFR), plus a 2-flop pad
// synchroniser, a previous-sample register and the edge qualifier.
//   clk, rst          : clock, asynchronous active-high reset
//   wr_data..wr_ifr   : decoded single-cycle write strobes from the bank
//   din               : write data
//   pol               : edge sense, 0 = falling, 1 = rising
//   warm_done         : high once the synchroniser has flushed after reset
//   port_i            : raw pad inputs (asynchronous to clk)
//   port_o, port_oe   : OR and DDR values driven to the pads
//   pin_view          : OR where driving, synchronised pad where not
//   ier, ifr          : register values for readback
//   irq_any           : at least one enabled flag is set
module gpio_port #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_data,
  input  logic             wr_ddr,
  input  logic             wr_ier,
  input  logic             wr_ifr,
  input  logic [WIDTH-1:0] din,
  input  logic             pol,
  input  logic             warm_done,
  input  logic [WIDTH-1:0] port_i,
  output logic [WIDTH-1:0] port_o,
  output logic [WIDTH-1:0] port_oe,
  output logic [WIDTH-1:0] pin_view,
  output logic [WIDTH-1:0] ier,
  output logic [WIDTH-1:0] ifr,
  output logic             irq_any
);

  logic [WIDTH-1:0] or_q, or_d;
  logic [WIDTH-1:0] ddr_q, ddr_d;
  logic [WIDTH-1:0] ier_q, ier_d;
  logic [WIDTH-1:0] ifr_q, ifr_d;
  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] ddr_prev_q, ddr_prev_d;

  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_qual;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    or_d       = or_q;
    ddr_d      = ddr_q;
    ier_d      = ier_q;
    s1_d       = port_i;
    s2_d       = s1_q;
    prev_d     = s2_q;
    ddr_prev_d = ddr_q;

    if (wr_data) or_d  = din;
    if (wr_ddr)  ddr_d = din;
    if (wr_ier)  ier_d = din;

    edge_raw = pol ? (s2_q & ~prev_q) : (~s2_q & prev_q);

    // Only input bits that were inputs last cycle too may flag, so flipping
    // a bit's direction can never masquerade as a pad edge.
    edge_qual = edge_raw & ~ddr_q & ~ddr_prev_q & {WIDTH{warm_done}};

    // Clear first, then OR in new edges: a set in the same cycle wins.
    ifr_d = ifr_q;
    if (wr_ifr) ifr_d = ifr_d & ~din;
    ifr_d = ifr_d | edge_qual;
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      or_q       <= '0;
      ddr_q      <= '0;
      ier_q      <= '0;
      ifr_q      <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      prev_q     <= '0;
      ddr_prev_q <= '0;
    end else begin
      or_q       <= or_d;
      ddr_q      <= ddr_d;
      ier_q      <= ier_d;
      ifr_q      <= ifr_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      prev_q     <= prev_d;
      ddr_prev_q <= ddr_prev_d;
    end
  end

  assign port_o   = or_q;
  assign port_oe  = ddr_q;
  assign pin_view = (or_q & ddr_q) | (s2_q & ~ddr_q);
  assign ier      = ier_q;
  assign ifr      = ifr_q;
  assign irq_any  = |(ifr_q & ier_q);

endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: NPORTS x WIDTH GPIO block on the internal chip bus.
// Per-port DATA/DDR/IER/IFR at base 4p, global POL at 4*NPORTS; read data is
// registered (one cycle latency) and irq is a registered OR of enabled flags.
//   clk, rst        : clock, asynchronous active-high reset
//   en, we, addr    : bus select, write/read, register address
//   din             : write data
//   dout, oe        : registered read data and its one-cycle valid
//   port_o, port_oe : output register and direction per bit, port p at [p*WIDTH +: WIDTH]
//   port_i          : asynchronous pad inputs
//   irq             : level interrupt request
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int WIDTH  = 8,
  parameter int AW     = $clog2(REGS_PER_PORT * NPORTS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    we,
  input  logic [AW-1:0]           addr,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic                    oe,
  output logic [NPORTS*WIDTH-1:0] port_o,
  output logic [NPORTS*WIDTH-1:0] port_oe,
  input  logic [NPORTS*WIDTH-1:0] port_i,
  output logic                    irq
);

  localparam logic [AW-1:0] POL_ADDR = AW'(pol_addr(NPORTS));

  logic             wr_en, rd_en;
  logic [WIDTH-1:0] pin_view [NPORTS];
  logic [WIDTH-1:0] ier      [NPORTS];
  logic [WIDTH-1:0] ifr      [NPORTS];
  logic [NPORTS-1:0] irq_any;

  logic [NPORTS-1:0] pol_q, pol_d;
  logic [1:0]        warm_q, warm_d;
  logic              warm_done;
  logic [WIDTH-1:0]  rdata;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              oe_q, oe_d;
  logic              irq_q, irq_d;

  assign wr_en     = en & we;
  assign rd_en     = en & ~we;
  assign warm_done = (warm_q == 2'd3);

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    localparam logic [AW-1:0] BASE = AW'(p * REGS_PER_PORT);

    gpio_port #(.WIDTH(WIDTH)) u_port (
      .clk       (clk),
      .rst       (rst),
      .wr_data   (wr_en && (addr == BASE + AW'(REG_DATA))),
      .wr_ddr    (wr_en && (addr == BASE + AW'(REG_DDR))),
      .wr_ier    (wr_en && (addr == BASE + AW'(REG_IER))),
      .wr_ifr    (wr_en && (addr == BASE + AW'(REG_IFR))),
      .din       (din),
      .pol       (pol_q[p]),
      .warm_done (warm_done),
      .port_i    (port_i[p*WIDTH +: WIDTH]),
      .port_o    (port_o[p*WIDTH +: WIDTH]),
      .port_oe   (port_oe[p*WIDTH +: WIDTH]),
      .pin_view  (pin_view[p]),
      .ier       (ier[p]),
      .ifr       (ifr[p]),
      .irq_any   (irq_any[p])
    );
  end

  // Read mux: unmapped addresses fall through to zero.
  always_comb begin
    rdata = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (addr == AW'(p * REGS_PER_PORT + REG_DATA)) rdata = pin_view[p];
      if (addr == AW'(p * REGS_PER_PORT + REG_DDR))  rdata = port_oe[p*WIDTH +: WIDTH];
      if (addr == AW'(p * REGS_PER_PORT + REG_IER))  rdata = ier[p];
      if (addr == AW'(p * REGS_PER_PORT + REG_IFR))  rdata = ifr[p];
    end
    if (addr == POL_ADDR) rdata[NPORTS-1:0] = pol_q;
  end

  always_comb begin
    pol_d  = pol_q;
    if (wr_en && (addr == POL_ADDR)) pol_d = din[NPORTS-1:0];

    // Saturates at 3: by then the synchroniser and prev hold real pad
    // samples, so a pad already high at reset cannot look like an edge.
    warm_d = warm_done ? warm_q : warm_q + 2'd1;

    dout_d = rd_en ? rdata : '0;
    oe_d   = rd_en;
    irq_d  = |irq_any;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pol_q  <= '0;
      warm_q <= '0;
      dout_q <= '0;
      oe_q   <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      pol_q  <= pol_d;
      warm_q <= warm_d;
      dout_q <= dout_d;
      oe_q   <= oe_d;
      irq_q  <= irq_d;
    end
  end

  assign dout = dout_q;
  assign oe   = oe_q;
  assign irq  = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed self-checking bench for gpio_bank (NPORTS=2, WIDTH=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_gpio_bank;

  localparam int NPORTS = 2;
  localparam int WIDTH  = 8;
  localparam int AW     = $clog2(4 * NPORTS + 1);

  // Register addresses for this configuration.
  localparam logic [AW-1:0] A_DATA0 = 4'd0;
  localparam logic [AW-1:0] A_DDR0  = 4'd1;
  localparam logic [AW-1:0] A_IER0  = 4'd2;
  localparam logic [AW-1:0] A_IFR0  = 4'd3;
  localparam logic [AW-1:0] A_DDR1  = 4'd5;
  localparam logic [AW-1:0] A_IER1  = 4'd6;
  localparam logic [AW-1:0] A_IFR1  = 4'd7;
  localparam logic [AW-1:0] A_POL   = 4'd8;
  localparam logic [AW-1:0] A_UNMAP = 4'd9;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    en, we;
  logic [AW-1:0]           addr;
  logic [WIDTH-1:0]        din;
  logic [WIDTH-1:0]        dout;
  logic                    oe;
  logic [NPORTS*WIDTH-1:0] port_o, port_oe, port_i;
  logic                    irq;

  int n_checks = 0;
  int n_errors = 0;

  gpio_bank #(.NPORTS(NPORTS), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .we      (we),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .oe      (oe),
    .port_o  (port_o),
    .port_oe (port_oe),
    .port_i  (port_i),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns on the falling edge after the write edge.
  task automatic bus_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    @(negedge clk);
    en = 1'b1; we = 1'b1; addr = a; din = d;
    @(negedge clk);
    en = 1'b0; we = 1'b0; din = '0;
  endtask

  // Issues one read; checks dout/oe in the following cycle.
  task automatic bus_read(input logic [AW-1:0] a, input string tag, input logic [WIDTH-1:0] exp);
    @(negedge clk);
    en = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    en = 1'b0;
    check({tag, " dout"}, {24'd0, dout}, {24'd0, exp});
    check({tag, " oe"}, {31'd0, oe}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; din = '0;
    // Bit 8 high and port 0 pads at 0x0C from before reset release.
    port_i = 16'h010C;
    idle(3);
    check("reset dout",    {24'd0, dout}, 32'd0);
    check("reset oe",      {31'd0, oe},   32'd0);
    check("reset irq",     {31'd0, irq},  32'd0);
    check("reset port_o",  {16'd0, port_o},  32'd0);
    check("reset port_oe", {16'd0, port_oe}, 32'd0);
    rst = 1'b0;

    // Direction, output register and pin view.
    bus_write(A_DDR0, 8'hF0);
    bus_write(A_DATA0, 8'hA5);
    check("port_oe0", {24'd0, port_oe[7:0]}, 32'hF0);
    check("port_o0",  {24'd0, port_o[7:0]},  32'hA5);
    @(negedge clk);
    check("oe idle before read", {31'd0, oe}, 32'd0);
    en = 1'b1; we = 1'b0; addr = A_DATA0;
    @(negedge clk);
    en = 1'b0;
    check("data0 pin view dout", {24'd0, dout}, 32'hAC);
    check("data0 pin view oe",   {31'd0, oe},   32'd1);
    @(negedge clk);
    check("oe single cycle",   {31'd0, oe},   32'd0);
    check("dout cleared",      {24'd0, dout}, 32'd0);

    // Pad high through reset: warm-up must suppress a flag.
    bus_read(A_IFR1, "ifr1 warmup", 8'h00);
    check("irq warmup", {31'd0, irq}, 32'd0);

    // Rising-edge flag and irq timing on port 1 bit 0.
    bus_write(A_POL, 8'h02);
    bus_write(A_IER1, 8'h01);
    bus_write(A_DDR1, 8'h00);
    port_i[8] = 1'b0;            // falling edge, ignored with rising sense
    idle(4);
    bus_read(A_IFR1, "ifr1 wrong sense", 8'h00);
    @(negedge clk);
    port_i[8] = 1'b1;
    idle(3);                     // flag set on this edge, irq not yet
    check("irq before flag+1", {31'd0, irq}, 32'd0);
    idle(1);
    check("irq after flag",    {31'd0, irq}, 32'd1);
    bus_read(A_IFR1, "ifr1 rise",        8'h01);
    bus_read(A_IFR1, "ifr1 read no clr", 8'h01);
    bus_write(A_IFR1, 8'h01);
    check("irq same edge as clr", {31'd0, irq}, 32'd1);
    idle(1);
    check("irq after clr", {31'd0, irq}, 32'd0);
    bus_read(A_IFR1, "ifr1 cleared", 8'h00);

    // Falling edge coincides with a W1C of the same bit: set wins.
    bus_write(A_POL, 8'h00);
    @(negedge clk);
    port_i[8] = 1'b0;
    idle(2);
    en = 1'b1; we = 1'b1; addr = A_IFR1; din = 8'h01;
    @(negedge clk);
    en = 1'b0; we = 1'b0; din = '0;
    bus_read(A_IFR1, "ifr1 set wins", 8'h01);
    bus_write(A_IFR1, 8'h01);
    bus_read(A_IFR1, "ifr1 cleared 2", 8'h00);

    // Direction change of bit 3 (pad 1, OR 0) must not flag.
    bus_write(A_DDR0, 8'hF8);
    idle(2);
    bus_write(A_DDR0, 8'hF0);
    idle(4);
    bus_read(A_IFR0, "ifr0 ddr toggle", 8'h00);

    // Falling edges on bit 2 (input) and bit 7 (output): only bit 2 flags.
    @(negedge clk);
    port_i[7] = 1'b1;
    idle(4);
    port_i[7] = 1'b0;
    port_i[2] = 1'b0;
    idle(4);
    bus_read(A_IFR0, "ifr0 input edge only", 8'h04);
    check("irq flag not enabled", {31'd0, irq}, 32'd0);
    bus_read(A_DATA0, "data0 after pad", 8'hA8);

    // Unmapped address and POL read-back width.
    bus_read(A_UNMAP, "unmapped", 8'h00);
    bus_write(A_POL, 8'hFF);
    bus_read(A_POL, "pol readback", 8'h03);

    // Enable the pending port 0 flag onto irq.
    bus_write(A_IER0, 8'h04);
    idle(1);
    check("irq ier enable", {31'd0, irq}, 32'd1);

    // Asynchronous reset in the middle of a read result and a pending write.
    @(negedge clk);
    en = 1'b1; we = 1'b0; addr = A_DATA0;
    @(negedge clk);
    check("oe before rst", {31'd0, oe}, 32'd1);
    en = 1'b1; we = 1'b1; addr = A_DATA0; din = 8'hFF;
    #2 rst = 1'b1;
    #1;
    check("async rst port_o",  {16'd0, port_o},  32'd0);
    check("async rst port_oe", {16'd0, port_oe}, 32'd0);
    check("async rst dout",    {24'd0, dout},    32'd0);
    check("async rst oe",      {31'd0, oe},      32'd0);
    check("async rst irq",     {31'd0, irq},     32'd0);
    @(negedge clk);
    en = 1'b0; we = 1'b0; din = '0;
    rst = 1'b0;
    idle(2);
    check("no partial write", {16'd0, port_o}, 32'd0);
    bus_read(A_IFR0, "ifr0 after rst", 8'h00);
    bus_read(A_DDR0, "ddr0 after rst", 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
